// File: rtl/adc_trigger_fill_if.sv
// ADC sample stream in, trace-RAM write port out.
// The DUT uses the slave modport; the ADC/RAM side uses the master modport.
interface adc_trigger_fill_if #(
  parameter int ADC_W  = 14,
  parameter int ADDR_W = 8
);
  logic              sample_en;
  logic [ADC_W-1:0]  adc_data;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;

  modport master (
    output sample_en,
    output adc_data,
    input  wr_data,
    input  wr_addr,
    input  wr_en
  );

  modport slave (
    input  sample_en,
    input  adc_data,
    output wr_data,
    output wr_addr,
    output wr_en
  );
endinterface

// File: rtl/adc_trigger_fill.sv
// Scales ADC samples to screen rows and captures one triggered trace into RAM.
// Optional auto-trigger after TIMEOUT samples: define TRIG_TIMEOUT_EN.
module adc_trigger_fill #(
  parameter int         ADC_W      = 14,
  parameter int         SHIFT      = 7,
  parameter int         OFFSET     = 4,
  parameter int         ADDR_W     = 8,
  parameter logic [7:0] TRIG_LEVEL = 8'd32,
  parameter int         TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  adc_trigger_fill_if.slave   bus,
  output logic                finished,
  output logic                triggered,
  output logic                timed_out
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_TRIG,
    CAPTURE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        prev_q, prev_d;
  logic [7:0]        wdat_q, wdat_d;
  logic [ADDR_W-1:0] wadr_q, wadr_d;
  logic              wen_q, wen_d;
  logic              fin_q, fin_d;
  logic              trg_q, trg_d;

  logic [ADC_W-1:0]  s;
  logic [7:0]        scaled;
  logic              hit;
  logic              tmo;
  logic [ADDR_W-1:0] nxt_adr;

  // Saturate at 0 instead of wrapping below the offset
  assign s      = bus.adc_data >> SHIFT;
  assign scaled = (s < ADC_W'(OFFSET)) ? 8'd0
                : 8'(s - ADC_W'(OFFSET));

  assign hit     = (prev_q < TRIG_LEVEL) &&
                   (scaled >= TRIG_LEVEL);
  assign nxt_adr = wadr_q + 1'b1;

`ifdef TRIG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          to_q, to_d;

  assign tmo       = (tcnt_q == TW'(TIMEOUT - 1));
  assign timed_out = to_q;
`else
  assign tmo       = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    wdat_d  = wdat_q;
    wadr_d  = wadr_q;
    wen_d   = 1'b0;
    fin_d   = fin_q;
    trg_d   = trg_q;
`ifdef TRIG_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    to_d    = to_q;
`endif
    if (!enable) begin
      state_d = IDLE;
      fin_d   = 1'b0;
      trg_d   = 1'b0;
`ifdef TRIG_TIMEOUT_EN
      to_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (bus.sample_en) begin
            prev_d  = scaled;
            state_d = WAIT_TRIG;
`ifdef TRIG_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end
        end
        WAIT_TRIG: begin
          if (bus.sample_en) begin
            if (hit || tmo) begin
              wen_d   = 1'b1;
              wdat_d  = scaled;
              wadr_d  = '0;
              trg_d   = 1'b1;
              state_d = CAPTURE;
`ifdef TRIG_TIMEOUT_EN
              to_d    = !hit;
`endif
            end else begin
              prev_d  = scaled;
`ifdef TRIG_TIMEOUT_EN
              tcnt_d  = tcnt_q + 1'b1;
`endif
            end
          end
        end
        CAPTURE: begin
          if (bus.sample_en) begin
            wen_d  = 1'b1;
            wdat_d = scaled;
            wadr_d = nxt_adr;
            // Last column: finished rises with this write
            if (&nxt_adr) begin
              state_d = DONE;
              fin_d   = 1'b1;
            end
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      wdat_q  <= '0;
      wadr_q  <= '0;
      wen_q   <= 1'b0;
      fin_q   <= 1'b0;
      trg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      wdat_q  <= wdat_d;
      wadr_q  <= wadr_d;
      wen_q   <= wen_d;
      fin_q   <= fin_d;
      trg_q   <= trg_d;
    end
  end

`ifdef TRIG_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      to_q   <= to_d;
    end
  end
`endif

  assign bus.wr_data = wdat_q;
  assign bus.wr_addr = wadr_q;
  assign bus.wr_en   = wen_q;
  assign finished    = fin_q;
  assign triggered   = trg_q;

endmodule

// File: tb/tb_adc_trigger_fill.sv
// Directed bench for adc_trigger_fill: scaling, trigger, abort, reset.
// Define TRIG_TIMEOUT_EN to exercise the auto-trigger path.
module tb_adc_trigger_fill;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic finished;
  logic triggered;
  logic timed_out;

  int vectors = 0;
  int miscompares = 0;
  int nwr = 0;

  adc_trigger_fill_if #(.ADC_W(14), .ADDR_W(8)) bus ();

  adc_trigger_fill dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .finished  (finished),
    .triggered (triggered),
    .timed_out (timed_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.wr_en === 1'b1) nwr++;

  function automatic logic [13:0] a(input int v);
    return 14'((v + 4) << 7);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic [13:0] d);
    bus.sample_en = 1'b1;
    bus.adc_data  = d;
    tick();
    bus.sample_en = 1'b0;
  endtask

  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    bus.sample_en = 1'b0;
    bus.adc_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_finished", 32'(finished), 0);
    chk("rst_triggered", 32'(triggered), 0);
    chk("rst_timed_out", 32'(timed_out), 0);

    // sample in IDLE is ignored
    samp(a(60));
    chk("idle_no_wr", 32'(bus.wr_en), 0);

    // scaling: 0 -> 0, 2000 -> 60, 3FFF -> 123
    enable = 1'b1;
    tick();
    samp(14'h0000);
    chk("arm_no_wr", 32'(bus.wr_en), 0);
    samp(14'h2000);
    chk("sc_2000_en", 32'(bus.wr_en), 1);
    chk("sc_2000_data", 32'(bus.wr_data), 60);
    chk("sc_2000_addr", 32'(bus.wr_addr), 0);
    chk("sc_trig", 32'(triggered), 1);
    samp(14'h3FFF);
    chk("sc_3fff_data", 32'(bus.wr_data), 123);
    chk("sc_3fff_addr", 32'(bus.wr_addr), 1);
    samp(14'h0000);
    chk("sc_0000_data", 32'(bus.wr_data), 0);
    chk("sc_0000_en", 32'(bus.wr_en), 1);

    // ramp 28..: trigger on 32, then 255 more writes
    restart();
    chk("restart_trig_clr", 32'(triggered), 0);
    samp(a(28));
    samp(a(29));
    samp(a(30));
    samp(a(31));
    chk("ramp_31_no_wr", 32'(bus.wr_en), 0);
    nwr = 0;
    samp(a(32));
    chk("ramp_first_data", 32'(bus.wr_data), 32);
    chk("ramp_first_addr", 32'(bus.wr_addr), 0);
    for (int i = 1; i < 256; i++) begin
      samp(a((32 + i) % 120));
      chk("ramp_data", 32'(bus.wr_data), 32'((32 + i) % 120));
      chk("ramp_addr", 32'(bus.wr_addr), 32'(i));
      if (i == 254)
        chk("ramp_fin_early", 32'(finished), 0);
    end
    chk("ramp_last_en", 32'(bus.wr_en), 1);
    chk("ramp_last_fin", 32'(finished), 1);
    samp(a(90));
    chk("done_no_wr", 32'(bus.wr_en), 0);
    chk("done_fin_hold", 32'(finished), 1);
    chk("ramp_count", 32'(nwr), 256);

    enable = 1'b0;
    tick();
    chk("dis_fin_clr", 32'(finished), 0);
    chk("dis_trig_clr", 32'(triggered), 0);

    // levels: prev above and equal to threshold do not trigger
    enable = 1'b1;
    tick();
    samp(a(40));
    samp(a(40));
    chk("lvl_40_40", 32'(bus.wr_en), 0);
    samp(a(32));
    chk("lvl_40_32", 32'(bus.wr_en), 0);
    samp(a(50));
    chk("lvl_prev_eq", 32'(bus.wr_en), 0);
    samp(a(20));
    chk("lvl_20", 32'(bus.wr_en), 0);
    nwr = 0;
    samp(a(40));
    chk("lvl_trig_en", 32'(bus.wr_en), 1);
    chk("lvl_trig_data", 32'(bus.wr_data), 40);
    chk("lvl_trig_addr", 32'(bus.wr_addr), 0);

    // abort after 100 writes, with a strobe squashed by enable=0
    for (int i = 1; i < 100; i++) samp(a(i % 100));
    chk("abort_addr", 32'(bus.wr_addr), 99);
    enable = 1'b0;
    samp(a(70));
    chk("abort_squash", 32'(bus.wr_en), 0);
    chk("abort_fin", 32'(finished), 0);
    chk("abort_trig", 32'(triggered), 0);
    samp(a(71));
    samp(a(72));
    tick();
    chk("abort_count", 32'(nwr), 100);
    enable = 1'b1;
    tick();
    samp(a(10));
    chk("rearm_no_wr", 32'(bus.wr_en), 0);
    samp(a(50));
    chk("rearm_trig_en", 32'(bus.wr_en), 1);
    chk("rearm_trig_addr", 32'(bus.wr_addr), 0);
    chk("rearm_trig_data", 32'(bus.wr_data), 50);

`ifdef TRIG_TIMEOUT_EN
    restart();
    samp(a(10));
    nwr = 0;
    for (int i = 1; i < 1024; i++) samp(a(10));
    chk("to_1023_no_wr", 32'(bus.wr_en), 0);
    samp(a(10));
    chk("to_en", 32'(bus.wr_en), 1);
    chk("to_addr", 32'(bus.wr_addr), 0);
    chk("to_flag", 32'(timed_out), 1);
    chk("to_trig", 32'(triggered), 1);
    for (int i = 1; i < 256; i++) samp(a(10));
    chk("to_fin", 32'(finished), 1);
    tick();
    chk("to_count", 32'(nwr), 256);
`else
    restart();
    nwr = 0;
    for (int i = 0; i < 5000; i++) samp(a(10));
    tick();
    chk("no_to_count", 32'(nwr), 0);
    chk("no_to_flag", 32'(timed_out), 0);
`endif

    // asynchronous reset mid-capture
    restart();
    samp(a(0));
    samp(a(50));
    samp(a(51));
    samp(a(52));
    chk("pre_rst_addr", 32'(bus.wr_addr), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_wr_en", 32'(bus.wr_en), 0);
    chk("arst_wr_addr", 32'(bus.wr_addr), 0);
    chk("arst_wr_data", 32'(bus.wr_data), 0);
    chk("arst_trig", 32'(triggered), 0);
    chk("arst_fin", 32'(finished), 0);
    chk("arst_to", 32'(timed_out), 0);
    enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    samp(a(60));
    chk("post_rst_idle", 32'(bus.wr_en), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
